// File: rtl/player_sprite_engine.sv
// Player sprite engine: animation FSM (idle/walk/hit-blink), per-frame position latch,
// and a two-stage pipeline turning the VGA beam position into a sprite-sheet ROM address.
module player_sprite_engine #(
  parameter int SPR_W     = 10,
  parameter int SPR_H     = 10,
  parameter int FRAMES    = 4,
  parameter int N_SKIN    = 3,
  parameter int SHEET_W   = 360,
  parameter int AW        = 17,
  parameter int TICK_DIV  = 2500000,
  parameter int HIT_TICKS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic [8:0]    pos_x,
  input  logic [8:0]    pos_y,
  input  logic [1:0]    skin,
  input  logic          facing_left,
  input  logic          moving,
  input  logic          hit,
  output logic [AW-1:0] pixel_addr,
  output logic          is_object,
  output logic [1:0]    anim_state
);

  localparam int CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int FW  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HW  = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
  localparam int TW  = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    HIT  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [FW-1:0] frame, frame_n;
  logic [HW-1:0] hit_left, hit_left_n;
  logic          blink, blink_n;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
  assign anim_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else     tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      frame    <= '0;
      hit_left <= '0;
      blink    <= 1'b0;
    end else begin
      state    <= state_n;
      frame    <= frame_n;
      hit_left <= hit_left_n;
      blink    <= blink_n;
    end
  end

  // A hit overrides everything, including a tick arriving in the same clock.
  always_comb begin
    state_n    = state;
    frame_n    = frame;
    hit_left_n = hit_left;
    blink_n    = blink;
    if (hit) begin
      state_n    = HIT;
      hit_left_n = HW'(HIT_TICKS - 1);
      blink_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_n = '0;
          if (moving) state_n = WALK;
        end
        WALK: begin
          if (!moving) begin
            state_n = IDLE;
            frame_n = '0;
          end else if (tick) begin
            frame_n = (frame == FW'(FRAMES - 1)) ? '0 : frame + FW'(1);
          end
        end
        HIT: begin
          if (tick) begin
            blink_n = ~blink;
            if (hit_left == '0) begin
              if (moving) begin
                state_n = WALK;
              end else begin
                state_n = IDLE;
                frame_n = '0;
              end
            end else begin
              hit_left_n = hit_left - HW'(1);
            end
          end
        end
        default: begin
          state_n = IDLE;
          frame_n = '0;
        end
      endcase
    end
  end

  // Shadow copy of the player, refreshed once per frame at the start of vblank.
  logic [8:0] sh_x, sh_y;
  logic [1:0] sh_skin;
  logic       sh_left, sh_valid;
  logic [1:0] skin_c;

  assign skin_c = (int'(skin) >= N_SKIN) ? 2'd0 : skin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_x     <= '0;
      sh_y     <= '0;
      sh_skin  <= '0;
      sh_left  <= 1'b0;
      sh_valid <= 1'b0;
    end else if (v_cnt == 10'd480 && h_cnt == 10'd0) begin
      sh_x     <= pos_x;
      sh_y     <= pos_y;
      sh_skin  <= skin_c;
      sh_left  <= facing_left;
      sh_valid <= 1'b1;
    end
  end

  // Stage 1: box test and in-sprite coordinates, 10-bit sums so the box never wraps.
  logic [9:0]     x10, y10, lx10, ly10;
  logic           active, in_box, draw;
  logic [CXW-1:0] cx_raw, cx;
  logic [RYW-1:0] ry;

  always_comb begin
    x10    = {1'b0, h_cnt[9:1]};
    y10    = {1'b0, v_cnt[9:1]};
    lx10   = {1'b0, sh_x};
    ly10   = {1'b0, sh_y};
    active = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    in_box = active
          && (x10 >= lx10) && (x10 < lx10 + 10'(SPR_W))
          && (y10 >= ly10) && (y10 < ly10 + 10'(SPR_H));
    draw   = en & sh_valid & in_box;
    cx_raw = CXW'(x10 - lx10);
    cx     = sh_left ? (CXW'(SPR_W - 1) - cx_raw) : cx_raw;
    ry     = RYW'(y10 - ly10);
  end

  logic           s1_draw, s1_blank;
  logic [CXW-1:0] s1_cx;
  logic [RYW-1:0] s1_ry;
  logic [FW-1:0]  s1_frame;
  logic [1:0]     s1_skin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_draw  <= 1'b0;
      s1_blank <= 1'b0;
      s1_cx    <= '0;
      s1_ry    <= '0;
      s1_frame <= '0;
      s1_skin  <= '0;
    end else begin
      s1_draw  <= draw;
      s1_blank <= (state == HIT) & blink;
      s1_cx    <= cx;
      s1_ry    <= ry;
      s1_frame <= frame;
      s1_skin  <= sh_skin;
    end
  end

  // Stage 2: sheet address; a blanked pixel keeps its address but drops is_object.
  logic [AW-1:0] addr_c;

  assign addr_c = (AW'(s1_ry) + AW'(s1_skin) * AW'(SPR_H)) * AW'(SHEET_W)
                + AW'(s1_frame) * AW'(SPR_W) + AW'(s1_cx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_addr <= '0;
      is_object  <= 1'b0;
    end else if (s1_draw) begin
      pixel_addr <= addr_c;
      is_object  <= ~s1_blank;
    end else begin
      pixel_addr <= '0;
      is_object  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_player_sprite_engine.sv
// Bench for player_sprite_engine: directed scenarios plus randomized traffic, all outputs
// compared every clock against a behavioural model of the sprite rules.
module tb_player_sprite_engine;

  localparam int SPR_W     = 10;
  localparam int SPR_H     = 10;
  localparam int FRAMES    = 4;
  localparam int N_SKIN    = 3;
  localparam int SHEET_W   = 360;
  localparam int AW        = 17;
  localparam int TICK_DIV  = 4;
  localparam int HIT_TICKS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [9:0]    h_cnt, v_cnt;
  logic [8:0]    pos_x, pos_y;
  logic [1:0]    skin;
  logic          facing_left, moving, hit;
  logic [AW-1:0] pixel_addr;
  logic          is_object;
  logic [1:0]    anim_state;

  player_sprite_engine #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .N_SKIN(N_SKIN),
    .SHEET_W(SHEET_W), .AW(AW), .TICK_DIV(TICK_DIV), .HIT_TICKS(HIT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .pos_x(pos_x), .pos_y(pos_y), .skin(skin), .facing_left(facing_left),
    .moving(moving), .hit(hit), .pixel_addr(pixel_addr), .is_object(is_object),
    .anim_state(anim_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model: animation state as plain integers, pixel rule as arithmetic
  int m_state, m_frame, m_tcnt, m_hleft, m_blink, m_valid;
  int sx, sy, ss, sl;
  logic [AW:0] exp_q[$];
  logic [AW:0] cur_exp;

  function automatic logic [AW:0] pixel_model(int h, int v, int en_i);
    int x, y, cx;
    logic [AW:0] r;
    x = h / 2;
    y = v / 2;
    r = '0;
    if (en_i != 0 && m_valid != 0 && h < 640 && v < 480 &&
        x >= sx && x < sx + SPR_W && y >= sy && y < sy + SPR_H) begin
      cx = (sl != 0) ? (SPR_W - 1 - (x - sx)) : (x - sx);
      r[AW-1:0] = AW'((y - sy + ss * SPR_H) * SHEET_W + m_frame * SPR_W + cx);
      r[AW] = !(m_state == 2 && m_blink != 0);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_frame = 0; m_tcnt = 0; m_hleft = 0; m_blink = 0; m_valid = 0;
    sx = 0; sy = 0; ss = 0; sl = 0;
    exp_q.delete();
    exp_q.push_back('0);
    cur_exp = '0;
  endtask

  task automatic model_edge();
    int tick_now;
    if (rst) begin
      model_reset();
      return;
    end
    cur_exp = exp_q.pop_front();
    exp_q.push_back(pixel_model(int'(h_cnt), int'(v_cnt), int'(en)));
    tick_now = (m_tcnt == TICK_DIV - 1) ? 1 : 0;
    m_tcnt = (m_tcnt + 1) % TICK_DIV;
    if (v_cnt == 10'd480 && h_cnt == 10'd0) begin
      sx = int'(pos_x); sy = int'(pos_y);
      ss = (int'(skin) >= N_SKIN) ? 0 : int'(skin);
      sl = int'(facing_left);
      m_valid = 1;
    end
    if (hit) begin
      m_state = 2; m_hleft = HIT_TICKS - 1; m_blink = 0;
    end else if (m_state == 0) begin
      m_frame = 0;
      if (moving) m_state = 1;
    end else if (m_state == 1) begin
      if (!moving) begin
        m_state = 0; m_frame = 0;
      end else if (tick_now != 0) begin
        m_frame = (m_frame + 1) % FRAMES;
      end
    end else if (tick_now != 0) begin
      m_blink = 1 - m_blink;
      if (m_hleft == 0) begin
        m_state = moving ? 1 : 0;
        if (!moving) m_frame = 0;
      end else begin
        m_hleft--;
      end
    end
  endtask

  // driver tasks
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("is_object", is_object, cur_exp[AW]);
    check("pixel_addr", pixel_addr, cur_exp[AW-1:0]);
    check("anim_state", anim_state, m_state);
  endtask

  task automatic do_latch(input int x, input int y, input int s, input int left);
    pos_x = 9'(x); pos_y = 9'(y); skin = 2'(s); facing_left = left[0];
    h_cnt = 10'd0; v_cnt = 10'd480;
    cyc();
    h_cnt = 10'd700; v_cnt = 10'd500;
  endtask

  task automatic scan(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      h_cnt = 10'(h); v_cnt = 10'(v);
      cyc();
    end
    h_cnt = 10'd700; v_cnt = 10'd100;
    cyc();
    cyc();
  endtask

  task automatic probe(input int h, input int v);
    h_cnt = 10'(h); v_cnt = 10'(v);
    cyc();
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int prev, nsteps, masked, dur, guard, t;
    rst = 1'b1; en = 1'b1; h_cnt = 10'd700; v_cnt = 10'd500;
    pos_x = '0; pos_y = '0; skin = '0; facing_left = 1'b0; moving = 1'b0; hit = 1'b0;
    model_reset();
    cyc();
    cyc();
    check("rst_addr", pixel_addr, 0);
    check("rst_state", anim_state, 0);
    rst = 1'b0;

    // before any latch nothing may be drawn, even over the all-zero shadow position
    for (int i = 0; i < 600; i++) begin
      if (i % 2 == 0) begin
        h_cnt = 10'($urandom_range(0, 40)); v_cnt = 10'($urandom_range(0, 40));
      end else begin
        h_cnt = 10'($urandom_range(0, 1023)); v_cnt = 10'($urandom_range(0, 479));
      end
      cyc();
    end

    // skin 1, facing right
    do_latch(100, 50, 1, 0);
    scan(100, 196, 224);
    probe(200, 100);
    check("right_x100_addr", pixel_addr, 3600);
    check("right_x100_obj", is_object, 1);
    probe(218, 100);
    check("right_x109_addr", pixel_addr, 3609);
    probe(199, 100);
    check("left_edge_off", is_object, 0);
    probe(220, 100);
    check("right_edge_off", is_object, 0);

    // mirrored
    do_latch(100, 50, 1, 1);
    scan(100, 196, 224);
    probe(200, 100);
    check("mirror_x100_addr", pixel_addr, 3609);
    probe(218, 100);
    check("mirror_x109_addr", pixel_addr, 3600);

    // walk cycle observed through the address of pixel (100,50)
    do_latch(100, 50, 1, 0);
    h_cnt = 10'd200; v_cnt = 10'd100;
    moving = 1'b1;
    cyc();
    check("walk_state", anim_state, 1);
    cyc();
    prev = int'(pixel_addr);
    nsteps = 0;
    for (int i = 0; i < 6 * TICK_DIV; i++) begin
      cyc();
      if (int'(pixel_addr) != prev) begin
        check("frame_step", pixel_addr, (prev == 3630) ? 3600 : prev + 10);
        nsteps++;
        prev = int'(pixel_addr);
      end
    end
    check("frame_steps_seen", (nsteps >= 5) ? 1 : 0, 1);
    moving = 1'b0;
    cyc();
    check("idle_after_stop", anim_state, 0);
    cyc();
    cyc();
    check("idle_frame0_addr", pixel_addr, 3600);

    // hit while walking, then a second hit part-way through
    moving = 1'b1;
    cyc();
    cyc();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    check("hit_state", anim_state, 2);
    masked = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (!is_object) masked++;
    end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    dur = 1;
    guard = 0;
    while (anim_state == 2'd2 && guard < 40) begin
      cyc();
      if (anim_state == 2'd2) dur++;
      if (!is_object) masked++;
      guard++;
    end
    check("hit_return_walk", anim_state, 1);
    check("hit_restart_duration", (dur >= 2 * TICK_DIV + 1 && dur <= 3 * TICK_DIV) ? 1 : 0, 1);
    check("blink_masked_seen", (masked > 0) ? 1 : 0, 1);

    // right-edge clipping and out-of-range skin
    moving = 1'b0;
    cyc();
    cyc();
    do_latch(315, 20, 3, 0);
    scan(46, 620, 645);
    scan(46, 0, 12);
    probe(630, 46);
    check("clip_x315_addr", pixel_addr, 1080);
    check("clip_x315_obj", is_object, 1);
    probe(638, 46);
    check("clip_x319_addr", pixel_addr, 1084);
    probe(0, 46);
    check("clip_nowrap_x0", is_object, 0);
    probe(640, 46);
    check("clip_x320_off", is_object, 0);

    // asynchronous reset in the middle of a drawn span
    do_latch(100, 50, 1, 0);
    probe(200, 100);
    check("pre_async_obj", is_object, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_obj", is_object, 0);
    check("async_rst_addr", pixel_addr, 0);
    model_reset();
    cyc();
    rst = 1'b0;
    scan(100, 196, 224);
    probe(200, 100);
    check("no_draw_after_rst", is_object, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      hit = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) moving = ~moving;
      en = ($urandom_range(0, 29) != 0);
      pos_x = 9'($urandom_range(0, 330));
      pos_y = 9'($urandom_range(0, 250));
      skin = 2'($urandom_range(0, 3));
      facing_left = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        h_cnt = 10'd0; v_cnt = 10'd480;
      end else if ($urandom_range(0, 9) < 7) begin
        t = 2 * sx + int'($urandom_range(0, 28)) - 4;
        h_cnt = 10'((t < 0) ? 0 : t);
        t = 2 * sy + int'($urandom_range(0, 28)) - 4;
        v_cnt = 10'((t < 0) ? 0 : t);
      end else begin
        h_cnt = 10'($urandom_range(0, 1023));
        v_cnt = 10'($urandom_range(0, 1023));
      end
      cyc();
    end
    hit = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
